data_memory_read_interface: RTL and testbench

//  Load-side counterpart of the stage-4 store lane placer. Tracks each load

---
 rtl/data_memory_read_interface.sv | 155 +++++++++++++++
 tb/tb_data_memory_read_interface.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_read_interface.sv
// data_memory_read_interface
// Load-side companion to the store lane placer. Each load's metadata travels
// alongside the synchronous data-memory read. When it reaches the pipe tail,
// the addressed byte, halfword or word is extracted from mem_rdata, then
// sign- or zero-extended and registered for writeback.
// load_type bit 0 selects byte, bit 1 selects halfword (byte wins if both
// are set), bit 2 selects zero-extension.

module data_memory_read_interface #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [2:0]  load_type,
    input  logic [4:0]  req_rd,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] load_value,
    output logic        misaligned
);

    localparam int LT_BYTE     = 0;
    localparam int LT_HWORD    = 1;
    localparam int LT_UNSIGNED = 2;

    typedef struct packed {
        logic       valid;
        logic [1:0] addr;
        logic [2:0] ltype;
        logic [4:0] rd;
    } meta_t;

    meta_t pipe_q [MEM_LATENCY];
    meta_t pipe_d [MEM_LATENCY];
    meta_t tail;

    logic        resp_valid_q, resp_valid_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic [31:0] load_value_q, load_value_d;
    logic        misaligned_q, misaligned_d;

    logic        is_byte;
    logic        is_hword;
    logic        is_unsigned;
    logic [7:0]  byte_val;
    logic [15:0] hword_val;
    logic [31:0] ext_value;
    logic        ext_misaligned;

    // Only the byte offset within the word matters here; the memory itself uses the rest.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:2];

    // Advance the metadata pipe in step with the memory read; a flush kills every in-flight load.
    always_comb begin
        for (int i = 0; i < MEM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (flush) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_d[i].valid = 1'b0;
            end
        end else if (!stall) begin
            pipe_d[0].valid = req_valid;
            pipe_d[0].addr  = req_addr[1:0];
            pipe_d[0].ltype = load_type;
            pipe_d[0].rd    = req_rd;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // Select and extend the addressed lane of the returned word, and flag bad alignment.
    always_comb begin
        tail        = pipe_q[MEM_LATENCY-1];
        is_byte     = tail.ltype[LT_BYTE];
        is_hword    = !tail.ltype[LT_BYTE] && tail.ltype[LT_HWORD];
        is_unsigned = tail.ltype[LT_UNSIGNED];
        byte_val    = mem_rdata[7:0];
        case (tail.addr)
            2'd0:    byte_val = mem_rdata[7:0];
            2'd1:    byte_val = mem_rdata[15:8];
            2'd2:    byte_val = mem_rdata[23:16];
            2'd3:    byte_val = mem_rdata[31:24];
            default: byte_val = mem_rdata[7:0];
        endcase
        hword_val      = tail.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext_value      = mem_rdata;
        ext_misaligned = 1'b0;
        if (is_byte) begin
            ext_value = {{24{byte_val[7] & ~is_unsigned}}, byte_val};
        end else if (is_hword) begin
            if (tail.addr[0]) begin
                ext_misaligned = 1'b1;
                ext_value      = 32'h0;
            end else begin
                ext_value = {{16{hword_val[15] & ~is_unsigned}}, hword_val};
            end
        end else if (tail.addr != 2'b00) begin
            ext_misaligned = 1'b1;
            ext_value      = 32'h0;
        end
    end

    // The response register follows the tail when not stalled; payload only changes on a valid tail.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rd_d    = resp_rd_q;
        load_value_d = load_value_q;
        misaligned_d = misaligned_q;
        if (flush) begin
            resp_valid_d = 1'b0;
        end else if (!stall) begin
            resp_valid_d = tail.valid;
            if (tail.valid) begin
                resp_rd_d    = tail.rd;
                load_value_d = ext_value;
                misaligned_d = ext_misaligned;
            end
        end
    end

    // State registers with immediate clearing on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            resp_valid_q <= 1'b0;
            resp_rd_q    <= 5'd0;
            load_value_q <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            load_value_q <= load_value_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rd    = resp_rd_q;
    assign load_value = load_value_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_data_memory_read_interface.sv
// Testbench for data_memory_read_interface.
// Two instances (latency 1 and latency 3) share the same stimulus and the same
// memory model. A queue-based reference model predicts every response.

module tb_data_memory_read_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  load_type;
    logic [4:0]  req_rd;
    logic        stall;
    logic        flush;

    logic        rv1, rv3, mis1, mis3;
    logic [4:0]  rrd1, rrd3;
    logic [31:0] lv1, lv3;
    logic [31:0] mem_rdata1, mem_rdata3;

    logic [31:0] mem [64];
    logic [31:0] mpipe [4];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: issued loads with the unstalled-edge count at issue.
    logic [31:0] exp_val [1024];
    logic        exp_mis [1024];
    logic [4:0]  exp_rd  [1024];
    int          exp_issue [1024];
    int          wr_ptr = 0;
    int          rd_ptr [2] = '{0, 0};
    int          lat [2] = '{1, 3};
    int          ucount = 0;
    logic        edge_reset = 1'b1;
    logic        edge_stall = 1'b0;
    logic        edge_flush = 1'b0;
    logic [38:0] prev_out [2];

    always #5 clk = ~clk;

    data_memory_read_interface #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .load_type(load_type), .req_rd(req_rd), .stall(stall), .flush(flush),
        .mem_rdata(mem_rdata1), .resp_valid(rv1), .resp_rd(rrd1),
        .load_value(lv1), .misaligned(mis1)
    );

    data_memory_read_interface #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .load_type(load_type), .req_rd(req_rd), .stall(stall), .flush(flush),
        .mem_rdata(mem_rdata3), .resp_valid(rv3), .resp_rd(rrd3),
        .load_value(lv3), .misaligned(mis3)
    );

    // Synchronous memory whose read enable is !stall; taps give latency 1 and 3.
    always @(posedge clk) begin
        if (!stall) begin
            mpipe[0] <= mem[req_addr[7:2]];
            mpipe[1] <= mpipe[0];
            mpipe[2] <= mpipe[1];
            mpipe[3] <= mpipe[2];
        end
    end
    assign mem_rdata1 = mpipe[0];
    assign mem_rdata3 = mpipe[2];

    // Architectural load semantics: {misaligned, value}.
    function automatic logic [32:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] lt);
        logic [31:0] s;
        logic [31:0] v;
        s = w >> (8 * a);
        if (lt[0]) begin
            v = s & 32'h0000_00FF;
            if (!lt[2] && s[7]) v = v | 32'hFFFF_FF00;
            return {1'b0, v};
        end else if (lt[1]) begin
            if (a[0]) return {1'b1, 32'h0};
            v = s & 32'h0000_FFFF;
            if (!lt[2] && s[15]) v = v | 32'hFFFF_0000;
            return {1'b0, v};
        end else if (a != 2'b00) begin
            return {1'b1, 32'h0};
        end
        return {1'b0, w};
    endfunction

    // Record what each clock edge did and enqueue accepted loads.
    always @(posedge clk) begin
        logic [32:0] r;
        edge_reset = reset;
        edge_stall = stall;
        edge_flush = flush;
        if (reset) begin
            rd_ptr[0] = wr_ptr;
            rd_ptr[1] = wr_ptr;
        end else begin
            if (!stall || flush) ucount++;
            if (flush) begin
                rd_ptr[0] = wr_ptr;
                rd_ptr[1] = wr_ptr;
            end else if (!stall && req_valid) begin
                r = ref_load(mem[req_addr[7:2]], req_addr[1:0], load_type);
                exp_val[wr_ptr]   = r[31:0];
                exp_mis[wr_ptr]   = r[32];
                exp_rd[wr_ptr]    = req_rd;
                exp_issue[wr_ptr] = ucount;
                wr_ptr++;
            end
        end
    end

    // Compare both instances against the model after every edge.
    always @(negedge clk) begin
        logic [38:0] obs [2];
        logic [38:0] want;
        obs[0] = {rv1, rrd1, lv1, mis1};
        obs[1] = {rv3, rrd3, lv3, mis3};
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (reset || edge_reset) begin
                if (obs[d] !== 39'h0) begin
                    tests_failed++;
                    $display("[TB] FAIL mon_reset_lat%0d: got %h expected 0", lat[d], obs[d]);
                end
            end else if (edge_flush) begin
                if (obs[d][38] !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL mon_flush_lat%0d: resp_valid got %b expected 0", lat[d], obs[d][38]);
                end
            end else if (edge_stall) begin
                if (obs[d] !== prev_out[d]) begin
                    tests_failed++;
                    $display("[TB] FAIL mon_stall_hold_lat%0d: got %h expected %h", lat[d], obs[d], prev_out[d]);
                end
            end else if (rd_ptr[d] < wr_ptr && ucount - exp_issue[rd_ptr[d]] == lat[d]) begin
                want = {1'b1, exp_rd[rd_ptr[d]], exp_val[rd_ptr[d]], exp_mis[rd_ptr[d]]};
                rd_ptr[d]++;
                if (obs[d] !== want) begin
                    tests_failed++;
                    $display("[TB] FAIL mon_resp_lat%0d: got %h expected %h", lat[d], obs[d], want);
                end
            end else begin
                if (obs[d][38] !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL mon_idle_lat%0d: resp_valid got %b expected 0", lat[d], obs[d][38]);
                end
            end
            prev_out[d] = obs[d];
        end
    end

    task automatic drive_idle();
        req_valid = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({rv1, rrd1, lv1, mis1} !== 39'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_lat1: got %h expected 0", {rv1, rrd1, lv1, mis1});
        end
        tests_run++;
        if ({rv3, rrd3, lv3, mis3} !== 39'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_lat3: got %h expected 0", {rv3, rrd3, lv3, mis3});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Single load with exact-cycle checks on both latencies.
    task automatic run_load(input string name, input logic [31:0] addr, input logic [2:0] lt,
                            input logic [4:0] rd, input logic [31:0] data,
                            input logic [31:0] want_val, input logic want_mis);
        mem[addr[7:2]] = data;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        load_type = lt;
        req_rd    = rd;
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (rv1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_early_lat1: resp_valid got %b expected 0", name, rv1);
        end
        @(negedge clk);
        tests_run++;
        if ({rv1, rrd1, lv1, mis1} !== {1'b1, rd, want_val, want_mis}) begin
            tests_failed++;
            $display("[TB] FAIL %s_lat1: got %h expected %h", name, {rv1, rrd1, lv1, mis1},
                     {1'b1, rd, want_val, want_mis});
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({rv3, rrd3, lv3, mis3} !== {1'b1, rd, want_val, want_mis}) begin
            tests_failed++;
            $display("[TB] FAIL %s_lat3: got %h expected %h", name, {rv3, rrd3, lv3, mis3},
                     {1'b1, rd, want_val, want_mis});
        end
        @(negedge clk);
    endtask

    task automatic test_directed_loads();
        run_load("lb",  32'h0000_0103, 3'b001, 5'd1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0);
        run_load("lbu", 32'h0000_0103, 3'b101, 5'd2, 32'h80FF_1234, 32'h0000_0080, 1'b0);
        run_load("lhu", 32'h0000_0102, 3'b110, 5'd3, 32'h80FF_1234, 32'h0000_80FF, 1'b0);
        run_load("lh",  32'h0000_0100, 3'b010, 5'd4, 32'h0000_F00D, 32'hFFFF_F00D, 1'b0);
        run_load("lw",  32'h0000_0104, 3'b000, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run_load("lbh", 32'h0000_0101, 3'b011, 5'd6, 32'h1234_8056, 32'hFFFF_FF80, 1'b0);
    endtask

    task automatic test_misaligned();
        run_load("lw_mis", 32'h0000_0106, 3'b000, 5'd9,  32'h1122_3344, 32'h0, 1'b1);
        run_load("lh_mis", 32'h0000_0103, 3'b010, 5'd10, 32'h1122_3344, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [4:0] tags [3];
        logic [4:0] seen1 [$];
        logic [4:0] seen3 [$];
        logic       last_stall;
        logic [31:0] addrs [3];
        logic [2:0]  lts [3];
        for (int i = 0; i < 3; i++) begin
            tags[i]  = 5'(i + 20);
            addrs[i] = 32'h200 + 32'($urandom_range(0, 63));
            lts[i]   = 3'($urandom_range(0, 7));
            mem[addrs[i][7:2]] = $urandom;
        end
        last_stall = 1'b0;
        for (int step = 0; step < 12; step++) begin
            @(negedge clk);
            if (!last_stall && rv1) seen1.push_back(rrd1);
            if (!last_stall && rv3) seen3.push_back(rrd3);
            drive_idle();
            if (step < 5) begin
                req_valid = 1'b1;
                req_addr  = addrs[(step < 2) ? step : 2];
                load_type = lts[(step < 2) ? step : 2];
                req_rd    = tags[(step < 2) ? step : 2];
                stall     = (step == 2 || step == 3);
            end
            last_stall = stall;
        end
        tests_run++;
        if (seen1.size() != 3 || seen3.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: got %0d/%0d responses expected 3/3", seen1.size(), seen3.size());
        end else begin
            tests_run++;
            if ({seen1[0], seen1[1], seen1[2], seen3[0], seen3[1], seen3[2]} !==
                {tags[0], tags[1], tags[2], tags[0], tags[1], tags[2]}) begin
                tests_failed++;
                $display("[TB] FAIL b2b_order: got %h expected %h",
                         {seen1[0], seen1[1], seen1[2], seen3[0], seen3[1], seen3[2]},
                         {tags[0], tags[1], tags[2], tags[0], tags[1], tags[2]});
            end
        end
    endtask

    task automatic test_flush();
        int cnt1;
        int cnt3;
        cnt1 = 0;
        cnt3 = 0;
        for (int step = 0; step < 11; step++) begin
            @(negedge clk);
            if (step >= 3) begin
                if (rv1) cnt1++;
                if (rv3) cnt3++;
            end
            drive_idle();
            if (step < 3) begin
                req_valid = 1'b1;
                req_addr  = 32'h300 + 32'(step * 4);
                load_type = 3'b000;
                req_rd    = 5'(step + 12);
                flush     = (step == 2);
            end
        end
        tests_run++;
        if (cnt1 != 0 || cnt3 != 0) begin
            tests_failed++;
            $display("[TB] FAIL flush_squash: got %0d/%0d responses expected 0/0", cnt1, cnt3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 63)] = $urandom;
            stall     = ($urandom_range(0, 9) < 2);
            flush     = ($urandom_range(0, 49) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = $urandom & 32'h0000_00FF;
            load_type = 3'($urandom_range(0, 7));
            req_rd    = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        drive_idle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0110;
        load_type = 3'b000;
        req_rd    = 5'd17;
        mem[6'h04] = 32'hCAFE_F00D;
        @(negedge clk);
        req_rd = 5'd18;
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({rv1, rrd1, lv1, mis1} !== 39'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_lat1: got %h expected 0", {rv1, rrd1, lv1, mis1});
        end
        tests_run++;
        if ({rv3, rrd3, lv3, mis3} !== 39'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_lat3: got %h expected 0", {rv3, rrd3, lv3, mis3});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        load_type = 3'b000;
        req_rd    = 5'd0;
        stall     = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mpipe[i] = 32'h0;
        test_reset();
        test_directed_loads();
        test_misaligned();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
